// File: rtl/mips_dmem_responder_pkg.sv
// Shared constants and FSM encoding for the MIPS data-memory responder.
package mips_mem_pkg;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned BE_W   = WORD_W / BYTE_W;
  localparam int unsigned CNT_W  = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WAIT = 2'b01,
    ST_RESP = 2'b10
  } dmem_state_e;

endpackage

// File: rtl/mips_dmem_responder_if.sv
// Load/store request-response bus between the core (master) and data memory (slave).
interface mips_dmem_if;
  import mips_mem_pkg::*;

  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [WORD_W-1:0] req_addr;
  logic [WORD_W-1:0] req_wdata;
  logic [BE_W-1:0]   req_be;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [WORD_W-1:0] rsp_rdata;
  logic              rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );

endinterface

// File: rtl/mips_dmem_responder_array.sv
// Word-organised data SRAM: byte-enabled synchronous write, asynchronous read, no reset.
module dmem_array
  import mips_mem_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = 8
) (
  input  logic                  clk_i,
  input  logic                  we_i,
  input  logic [BE_W-1:0]       be_i,
  input  logic [DEPTH_LOG2-1:0] addr_i,
  input  logic [WORD_W-1:0]     wdata_i,
  output logic [WORD_W-1:0]     rdata_o
);

  logic [WORD_W-1:0] mem_q [2**DEPTH_LOG2];

  // Byte-lane write port
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int i = 0; i < BE_W; i++) begin
        if (be_i[i]) begin
          mem_q[addr_i][i*BYTE_W +: BYTE_W] <= wdata_i[i*BYTE_W +: BYTE_W];
        end
      end
    end
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/mips_dmem_responder.sv
// Data-memory responder: one outstanding request, programmable wait states, range-checked access.
// Optional feature: DMEM_ALIGN_CHECK_EN rejects accesses with addr[1:0] != 0.
module mips_dmem_responder
  import mips_mem_pkg::*;
#(
  parameter int unsigned  DEPTH_LOG2 = 8,
  parameter int unsigned  RD_LATENCY = 2,
  parameter logic [31:0]  BASE_ADDR  = 32'h0000_0000
) (
  input  logic        in_clock,
  input  logic        reset,
  mips_dmem_if.slave  bus
);

  localparam logic [CNT_W-1:0] CNT_LOAD  = CNT_W'(RD_LATENCY);
  localparam logic [29:0]      BASE_WORD = BASE_ADDR[31:2];

  dmem_state_e       state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [WORD_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;

  logic              we_q;
  logic [29:0]       addr_word_q;
  logic [WORD_W-1:0] wdata_q;
  logic [BE_W-1:0]   be_q;

  logic              capture_s;
  logic              mem_we_s;
  logic [30:0]       word_off_s;
  logic              in_range_s;
  logic              align_ok_s;
  logic              access_ok_s;
  logic [WORD_W-1:0] mem_rdata_s;

  // Word offset computed one bit wider so addresses below BASE show up as a set MSB
  assign word_off_s  = {1'b0, addr_word_q} - {1'b0, BASE_WORD};
  assign in_range_s  = (word_off_s[30:DEPTH_LOG2] == {(31-DEPTH_LOG2){1'b0}});

`ifdef DMEM_ALIGN_CHECK_EN
  logic [1:0] addr_lo_q;

  // Low address bits kept only when alignment is checked
  always_ff @(posedge in_clock) begin
    if (capture_s) begin
      addr_lo_q <= bus.req_addr[1:0];
    end
  end

  assign align_ok_s = (addr_lo_q == 2'b00);
`else
  assign align_ok_s = 1'b1;
`endif

  assign access_ok_s = in_range_s && align_ok_s;

  // Request capture registers (datapath only, not reset)
  always_ff @(posedge in_clock) begin
    if (capture_s) begin
      we_q        <= bus.req_we;
      addr_word_q <= bus.req_addr[31:2];
      wdata_q     <= bus.req_wdata;
      be_q        <= bus.req_be;
    end
  end

  // Control and response state registers
  always_ff @(posedge in_clock or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= {CNT_W{1'b0}};
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= {WORD_W{1'b0}};
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  // Next-state, wait countdown and response formation
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    capture_s   = 1'b0;
    mem_we_s    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.req_valid) begin
          capture_s = 1'b1;
          cnt_d     = CNT_LOAD;
          state_d   = ST_WAIT;
        end else begin
          state_d   = ST_IDLE;
        end
      end
      ST_WAIT: begin
        // A zero count performs the access on this edge, giving RD_LATENCY+1 total
        if (cnt_q == {CNT_W{1'b0}}) begin
          mem_we_s    = we_q && access_ok_s;
          rsp_valid_d = 1'b1;
          rsp_err_d   = !access_ok_s;
          rsp_rdata_d = (!we_q && access_ok_s) ? mem_rdata_s : {WORD_W{1'b0}};
          state_d     = ST_RESP;
        end else begin
          cnt_d       = cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
      ST_RESP: begin
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end else begin
          state_d     = ST_RESP;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        rsp_valid_d = 1'b0;
      end
    endcase
  end

  dmem_array #(
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_array (
    .clk_i   (in_clock),
    .we_i    (mem_we_s),
    .be_i    (be_q),
    .addr_i  (word_off_s[DEPTH_LOG2-1:0]),
    .wdata_i (wdata_q),
    .rdata_o (mem_rdata_s)
  );

  assign bus.req_ready = (state_q == ST_IDLE);
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_mips_dmem_responder.sv
// Self-checking bench: table of load/store vectors scored through an expected-response queue.
module tb_mips_dmem_responder;
  import mips_mem_pkg::*;

  localparam int unsigned LAT = 2;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic        exp_err;
    logic [31:0] exp_rdata;
  } vec_t;

  typedef struct {
    logic        err;
    logic [31:0] rdata;
  } exp_t;

  logic in_clock = 1'b0;
  logic reset    = 1'b1;
  int   checks   = 0;
  int   errors   = 0;
  exp_t sb_q[$];
  vec_t vecs[$];

  mips_dmem_if bus ();

  mips_dmem_responder #(
    .DEPTH_LOG2 (8),
    .RD_LATENCY (LAT),
    .BASE_ADDR  (32'h0000_0000)
  ) dut (
    .in_clock (in_clock),
    .reset    (reset),
    .bus      (bus)
  );

  always #5 in_clock = ~in_clock;

  initial begin
    #200000;
    $display("FAIL global_timeout act=running exp=finished");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  // Issue one request, check latency, optional backpressure, then score the response
  task automatic do_txn(input vec_t v, input int hold);
    exp_t e;
    exp_t got;
    int   k;
    @(negedge in_clock);
    chk("req_ready_idle", {31'd0, bus.req_ready}, 32'd1);
    bus.req_valid = 1'b1;
    bus.req_we    = v.we;
    bus.req_addr  = v.addr;
    bus.req_wdata = v.wdata;
    bus.req_be    = v.be;
    @(posedge in_clock);
    sb_q.push_back('{v.exp_err, v.exp_rdata});
    #1;
    bus.req_valid = 1'b0;
    bus.req_addr  = 32'hxxxx_xxxx;
    bus.req_wdata = 32'hxxxx_xxxx;
    k = 0;
    while (k < 20 && bus.rsp_valid !== 1'b1) begin
      @(posedge in_clock);
      #1;
      k++;
    end
    chk("latency", k, LAT + 1);
    if (bus.rsp_valid !== 1'b1) return;
    got.err   = bus.rsp_err;
    got.rdata = bus.rsp_rdata;
    for (int c = 0; c < hold; c++) begin
      @(posedge in_clock);
      #1;
      chk("bp_valid", {31'd0, bus.rsp_valid}, 32'd1);
      chk("bp_ready", {31'd0, bus.req_ready}, 32'd0);
      chk("bp_rdata", bus.rsp_rdata, got.rdata);
    end
    bus.rsp_ready = 1'b1;
    @(posedge in_clock);
    #1;
    bus.rsp_ready = 1'b0;
    if (sb_q.size() == 0) begin
      chk("sb_empty", 32'd0, 32'd1);
    end else begin
      e = sb_q.pop_front();
      chk("rsp_err", {31'd0, got.err}, {31'd0, e.err});
      chk("rsp_rdata", got.rdata, e.rdata);
    end
    chk("post_hs_valid", {31'd0, bus.rsp_valid}, 32'd0);
    chk("post_hs_ready", {31'd0, bus.req_ready}, 32'd1);
  endtask

  initial begin
    vec_t        v;
    logic        al_err;
    logic [31:0] al_data;
`ifdef DMEM_ALIGN_CHECK_EN
    al_err  = 1'b1;
    al_data = 32'h0000_0000;
`else
    al_err  = 1'b0;
    al_data = 32'hDE22_BE44;
`endif
    vecs.push_back('{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'b1111, 1'b0, 32'h0000_0000});
    vecs.push_back('{1'b0, 32'h0000_0010, 32'h0000_0000, 4'b0000, 1'b0, 32'hDEAD_BEEF});
    vecs.push_back('{1'b1, 32'h0000_0010, 32'h1122_3344, 4'b0101, 1'b0, 32'h0000_0000});
    vecs.push_back('{1'b0, 32'h0000_0010, 32'h0000_0000, 4'b1111, 1'b0, 32'hDE22_BE44});
    vecs.push_back('{1'b0, 32'h0000_0400, 32'h0000_0000, 4'b1111, 1'b1, 32'h0000_0000});
    vecs.push_back('{1'b1, 32'h0000_0400, 32'hCAFE_F00D, 4'b1111, 1'b1, 32'h0000_0000});
    vecs.push_back('{1'b1, 32'h0000_03FC, 32'h0A0B_0C0D, 4'b1111, 1'b0, 32'h0000_0000});
    vecs.push_back('{1'b0, 32'h0000_03FC, 32'h0000_0000, 4'b0000, 1'b0, 32'h0A0B_0C0D});
    vecs.push_back('{1'b1, 32'h0000_0010, 32'hFFFF_FFFF, 4'b0000, 1'b0, 32'h0000_0000});
    vecs.push_back('{1'b0, 32'h0000_0010, 32'h0000_0000, 4'b1111, 1'b0, 32'hDE22_BE44});
    vecs.push_back('{1'b0, 32'h0000_0012, 32'h0000_0000, 4'b1111, al_err, al_data});
    vecs.push_back('{1'b0, 32'hFFFF_FFFC, 32'h0000_0000, 4'b1111, 1'b1, 32'h0000_0000});
    vecs.push_back('{1'b1, 32'h0000_0020, 32'hA5A5_A5A5, 4'b1111, 1'b0, 32'h0000_0000});

    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_addr  = 32'h0000_0000;
    bus.req_wdata = 32'h0000_0000;
    bus.req_be    = 4'b0000;
    bus.rsp_ready = 1'b0;

    repeat (3) @(posedge in_clock);
    #1;
    chk("rst_req_ready", {31'd0, bus.req_ready}, 32'd1);
    chk("rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    chk("rst_rsp_rdata", bus.rsp_rdata, 32'd0);
    chk("rst_rsp_err", {31'd0, bus.rsp_err}, 32'd0);
    @(negedge in_clock);
    reset = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      do_txn(vecs[i], 0);
    end

    // Backpressure: response held five cycles
    v = '{1'b0, 32'h0000_0010, 32'h0000_0000, 4'b1111, 1'b0, 32'hDE22_BE44};
    do_txn(v, 5);

    // Reset during the wait of a store: the store must not land
    @(negedge in_clock);
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b1;
    bus.req_addr  = 32'h0000_0020;
    bus.req_wdata = 32'h0000_0055;
    bus.req_be    = 4'b1111;
    @(posedge in_clock);
    #1;
    bus.req_valid = 1'b0;
    @(posedge in_clock);
    #1;
    reset = 1'b1;
    #1;
    chk("midrst_req_ready", {31'd0, bus.req_ready}, 32'd1);
    chk("midrst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    chk("midrst_rsp_rdata", bus.rsp_rdata, 32'd0);
    chk("midrst_rsp_err", {31'd0, bus.rsp_err}, 32'd0);
    repeat (3) @(posedge in_clock);
    @(negedge in_clock);
    reset = 1'b0;
    #1;
    chk("after_rst_valid", {31'd0, bus.rsp_valid}, 32'd0);

    v = '{1'b0, 32'h0000_0020, 32'h0000_0000, 4'b0000, 1'b0, 32'hA5A5_A5A5};
    do_txn(v, 0);

    chk("sb_drained", sb_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
